// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the multiply/divide unit: command codes, FSM states
// and default operation lengths.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Commands that occupy the unit for several cycles and later write HI/LO.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// Combinational MDU datapath: 64-bit {hi,lo} result for mult/multu/div/divu
// plus a divide-by-zero flag.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  md_op_i,
    output logic [63:0] res_o,
    output logic        div_zero_o
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] mag_a;
    logic        [31:0] mag_b;
    logic        [31:0] dvs;
    logic        [31:0] quo;
    logic        [31:0] rem;
    logic               is_signed;
    logic               neg_q;
    logic               neg_r;

    always_comb begin
        prod_s     = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
        prod_u     = {32'd0, a_i} * {32'd0, b_i};
        is_signed  = (md_op_i == MD_DIV);
        // Signed division works on magnitudes so 0x80000000 / -1 needs no special case.
        mag_a      = (is_signed && a_i[31]) ? -a_i : a_i;
        mag_b      = (is_signed && b_i[31]) ? -b_i : b_i;
        div_zero_o = (b_i == 32'd0);
        dvs        = div_zero_o ? 32'd1 : mag_b;
        quo        = mag_a / dvs;
        rem        = mag_a % dvs;
        neg_q      = is_signed & (a_i[31] ^ b_i[31]);
        neg_r      = is_signed & a_i[31];

        res_o = 64'd0;
        case (md_op_i)
            MD_MULT:          res_o = $unsigned(prod_s);
            MD_MULTU:         res_o = prod_u;
            MD_DIV, MD_DIVU:  res_o = {(neg_r ? -rem : rem), (neg_q ? -quo : quo)};
            default:          res_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: fixed-latency FSM, HI/LO ownership and the
// stall request for MDU-touching instructions waiting in D.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_md
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    mdu_state_e  state_q;
    logic [3:0]  cnt_q;
    logic [63:0] res_q;
    logic        dz_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [63:0] arith_res;
    logic        arith_dz;
    logic        long_op;
    logic        div_op;

    mdu_arith u_arith (
        .a_i        (a),
        .b_i        (b),
        .md_op_i    (md_op),
        .res_o      (arith_res),
        .div_zero_o (arith_dz)
    );

    assign long_op = is_long_op(md_op);
    assign div_op  = is_div_op(md_op);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            res_q   <= 64'd0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else if (state_q == ST_IDLE) begin
            if (start && long_op) begin
                res_q   <= arith_res;
                dz_q    <= div_op & arith_dz;
                cnt_q   <= div_op ? DIV_CNT : MULT_CNT;
                state_q <= ST_RUN;
            end else if (start && md_op == MD_MTHI) begin
                hi_q <= a;
            end else if (start && md_op == MD_MTLO) begin
                lo_q <= a;
            end
        end else begin
            // Commands arriving while running are dropped; the hazard unit keeps them out.
            if (cnt_q == 4'd1) begin
                if (!dz_q) begin
                    hi_q <= res_q[63:32];
                    lo_q <= res_q[31:0];
                end
                cnt_q   <= 4'd0;
                state_q <= ST_IDLE;
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q == ST_RUN);
    assign stall_md = md_use_D & (busy | (start & long_op));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_D;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_md;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .a        (a),
        .b        (b),
        .md_use_D (md_use_D),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stall_md (stall_md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       nm;
        logic [65:0] v;   // {hi, lo, busy, stall_md}
    } exp_t;

    exp_t        sb[$];
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle, compare all expectations due now.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [65:0] act;
            e   = sb.pop_front();
            act = {hi, lo, busy, stall_md};
            total++;
            if (e.cyc < cyc) begin
                bad++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.nm, e.cyc, cyc);
            end else if (act !== e.v) begin
                bad++;
                $display("FAIL %s @%0d: got hi=%h lo=%h busy=%b stall=%b, want hi=%h lo=%h busy=%b stall=%b",
                         e.nm, cyc, act[65:34], act[33:2], act[1], act[0],
                         e.v[65:34], e.v[33:2], e.v[1], e.v[0]);
            end
        end
    end

    task automatic push(input int c, input string nm, input logic [31:0] h, input logic [31:0] l,
                        input logic bz, input logic st);
        exp_t e;
        e.cyc = c;
        e.nm  = nm;
        e.v   = {h, l, bz, st};
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input logic use_d, input string nm);
        push(cyc, nm, m_hi, m_lo, 1'b0, 1'b0);
        md_use_D = use_d;
        step();
        md_use_D = 1'b0;
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] av, input string nm);
        push(cyc, nm, m_hi, m_lo, 1'b0, 1'b0);
        start    = 1'b1;
        md_op    = op;
        a        = av;
        md_use_D = 1'b1;
        if (op == 3'd5) m_hi = av;
        else            m_lo = av;
        step();
        start    = 1'b0;
        md_op    = 3'd0;
        md_use_D = 1'b0;
    endtask

    // Issue a long op in the current cycle; returns in the first cycle after busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input int ncyc, input logic [31:0] rhi, input logic [31:0] rlo,
                          input logic use_d, input int inj_k, input int rst_k, input string nm);
        int n;
        n = cyc;
        push(n, {nm, "_start"}, m_hi, m_lo, 1'b0, use_d);
        for (int k = 1; k <= ncyc; k++) begin
            if (rst_k != 0 && k > rst_k)
                push(n + k, {nm, "_rst"}, 32'd0, 32'd0, 1'b0, 1'b0);
            else
                push(n + k, {nm, "_busy"}, m_hi, m_lo, 1'b1, use_d);
        end
        if (rst_k != 0) begin
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else begin
            m_hi = rhi;
            m_lo = rlo;
        end
        start    = 1'b1;
        md_op    = op;
        a        = av;
        b        = bv;
        md_use_D = use_d;
        for (int k = 1; k <= ncyc; k++) begin
            step();
            start = 1'b0;
            md_op = 3'd0;
            reset = 1'b0;
            if (k == inj_k) begin
                start = 1'b1;
                md_op = 3'd5;
                a     = 32'hDEADBEEF;
            end
            if (k == rst_k) reset = 1'b1;
        end
        step();
        start    = 1'b0;
        reset    = 1'b0;
        md_op    = 3'd0;
        md_use_D = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        md_op    = 3'd0;
        a        = 32'd0;
        b        = 32'd0;
        md_use_D = 1'b0;
        m_hi     = 32'd0;
        m_lo     = 32'd0;
        step();
        step();
        reset = 1'b0;

        idle_check(1'b1, "reset");
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 0, 0, "mult");
        idle_check(1'b0, "mult_done");
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0, 0, "multu");
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, 0, "div");
        run_op(3'd4, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, 0, "divu0");
        idle_check(1'b0, "divu0_done");
        run_op(3'd1, 32'd7, 32'd6, 5, 32'd0, 32'd42, 1'b1, 0, 0, "mult_stall");
        idle_check(1'b1, "stall_clear");
        run_op(3'd2, 32'h00010000, 32'h00010000, 5, 32'd1, 32'd0, 1'b1, 0, 0, "multu_b2b");
        mt(3'd5, 32'h12345678, "mthi");
        mt(3'd6, 32'h9ABCDEF0, "mtlo");
        idle_check(1'b0, "mt_done");
        run_op(3'd1, 32'h80000000, 32'd2, 5, 32'hFFFFFFFF, 32'h00000000, 1'b0, 2, 0, "mult_inj");
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 1'b0, 0, 0, "div_ovf");
        run_op(3'd3, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD, 1'b0, 0, 0, "div_negb");
        run_op(3'd4, 32'hFFFFFFFF, 32'd10, 10, 32'd5, 32'h19999999, 1'b0, 0, 0, "divu");
        mt(3'd5, 32'h0BADF00D, "mthi2");
        run_op(3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0, 0, 4, "div_reset");
        idle_check(1'b0, "post_reset");
        idle_check(1'b0, "post_reset2");

        step();
        step();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: expectation for cycle %0d never checked", e.nm, e.cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the five-stage pipeline. It accepts one mult/multu/div/divu/mthi/mtlo command from the E stage and runs the operation for a fixed number of cycles. It owns the HI/LO registers and raises a stall request to the hazard unit while any MDU-touching instruction in D must wait. The block sits beside the ALU in E; `stall_md` is ORed into the existing stall term, which drives pc_en, d_en and e_reset.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  E-stage command valid this cycle
- md_op  input  3  command: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6
- a  input  32  E-stage forwarded rs value
- b  input  32  E-stage forwarded rt value
- md_use_D  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- hi  output  32  HI register (read by mfhi in E)
- lo  output  32  LO register (read by mflo in E)
- busy  output  1  operation in progress
- stall_md  output  1  stall request to hazard unit

## Operation
- States: IDLE, RUN. The 4-bit down-counter `cnt` and the 64-bit result latch `res` are valid only in RUN.
- IDLE + start + op ∈ {MULT, MULTU, DIV, DIVU}:
  - compute the result from a, b into `res` at this edge;
  - load `cnt` = MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- Divide by zero: the command still takes DIV_CYCLES, but HI/LO are left unchanged at completion.
- IDLE + start + MTHI: hi ← a at this edge; no RUN.
- IDLE + start + MTLO: lo ← a at this edge; no RUN.
- IDLE + start + MD_NONE, or any op code 7: ignored.
- RUN: `cnt` decrements each cycle. When `cnt`==1, {hi,lo} ← `res` at that edge and the state returns to IDLE.
- start while in RUN: ignored; HI/LO and `cnt` are unaffected. This is a protocol violation that the hazard unit prevents.
- Arithmetic:
  - mult: signed 32×32→64, hi = product[63:32], lo = product[31:0];
  - multu: the same product, unsigned;
  - div: signed, quotient → lo, remainder → hi; the quotient truncates toward zero and the remainder takes the sign of the dividend;
  - divu: unsigned;
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0.
- busy = (state==RUN). It is a registered value.
- stall_md = md_use_D & (busy | (start & md_op ∈ {MULT, MULTU, DIV, DIVU})). It is combinational.
- reset in any state: next edge gives state=IDLE, cnt=0, res=0, hi=0, lo=0. Any in-flight operation is discarded.

## Timing
- Reset values: hi=0, lo=0, busy=0. stall_md=0 whenever md_use_D=0 or start=0 after reset.
- For start at edge t with op=mult:
  - busy=1 during cycles t+1 … t+MULT_CYCLES;
  - new hi/lo are visible from cycle t+MULT_CYCLES+1, the same cycle busy falls.
- Div behaves the same way with DIV_CYCLES.
- An mfhi/mflo in D is stalled through the last busy cycle. It enters E in the first cycle with busy=0 and reads the new HI/LO.
- A back-to-back MDU command can issue start in the first cycle after busy falls. There are no dead cycles.
- MTHI/MTLO latency is 1: a value written at edge t is readable in cycle t+1.
- Start and reset in the same cycle: reset wins.

## Structure
- MD_* op encodings and the default cycle counts go in the shared `const.v` as defines, next to the opcode/func constants. The decoder that produces md_op uses the same defines.
- One sub-module: `mdu_arith`, purely combinational (a, b, md_op → 64-bit {hi,lo} result, plus a div-by-zero flag).
- The FSM, counter, `res` and the HI/LO registers stay in `mdu_ctrl`.

## Test plan
- Reset, then mult a=0xFFFFFFFE, b=3 → busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- div a=-7 (0xFFFFFFF9), b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu a=7, b=0 → 10 busy cycles, hi/lo unchanged.
- md_use_D=1 held while mult is issued:
  - stall_md=1 in the start cycle and all 5 busy cycles;
  - stall_md=0 in cycle t+6;
  - a second start in cycle t+6 is accepted.
- mthi a=0x12345678, then mtlo a=0x9ABCDEF0 in consecutive cycles → hi/lo updated one cycle after each. A start during RUN (mthi a=0xDEADBEEF) is ignored.
- div issued, then reset asserted on the 4th busy cycle → the next cycle has busy=0 and hi=lo=0. No late write-back occurs at cycle t+11.
